// File: rtl/psum_accumulator.sv
// Accumulates per-column partial sums over a job of num_tiles tiles into signed,
// saturating per-lane accumulators, then presents the result via valid/ready.
module psum_accumulator #(
  parameter int ARRAY_SIZE = 8,
  parameter int COL_WIDTH  = 13,
  parameter int ACC_WIDTH  = 64,
  parameter int TILE_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [TILE_W-1:0]               num_tiles,
  input  logic                            psum_valid,
  input  logic [ARRAY_SIZE*COL_WIDTH*4-1:0] psums,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0] acc_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic [ARRAY_SIZE-1:0]           sat,
  output logic                            dropped
);

  localparam int PSUM_W = COL_WIDTH * 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [1:0]                     state_q, state_d;
  logic [TILE_W-1:0]              cnt_q, cnt_d;
  logic [TILE_W-1:0]              tgt_q, tgt_d;
  logic [ARRAY_SIZE*ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ARRAY_SIZE-1:0]          sat_q, sat_d;
  logic                           dropped_q, dropped_d;
  logic                           load_job;

  function automatic logic [ACC_WIDTH-1:0] sext(input logic [PSUM_W-1:0] p);
    return ACC_WIDTH'($signed(p));
  endfunction

  // Signed overflow: operands share a sign and the wrapped sum does not.
  function automatic logic add_ovf(input logic [ACC_WIDTH-1:0] a,
                                   input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH-1:0] s;
    s = a + b;
    return (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
  endfunction

  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [ACC_WIDTH-1:0] b);
    if (add_ovf(a, b)) begin
      return a[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end
    return a + b;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    dropped_d = dropped_q;
    load_job  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (psum_valid) dropped_d = 1'b1;
        if (start) load_job = 1'b1;
      end
      S_ACCUM: begin
        if (psum_valid) begin
          for (int i = 0; i < ARRAY_SIZE; i++) begin
            acc_d[i*ACC_WIDTH +: ACC_WIDTH] =
              sat_add(acc_q[i*ACC_WIDTH +: ACC_WIDTH], sext(psums[i*PSUM_W +: PSUM_W]));
            sat_d[i] = sat_q[i] |
              add_ovf(acc_q[i*ACC_WIDTH +: ACC_WIDTH], sext(psums[i*PSUM_W +: PSUM_W]));
          end
          cnt_d = cnt_q + TILE_W'(1);
          if (cnt_q == tgt_q - TILE_W'(1)) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (psum_valid) dropped_d = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
          if (start) load_job = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new job can begin from IDLE or on the same edge as a HOLD handshake.
    if (load_job) begin
      tgt_d   = (num_tiles == '0) ? TILE_W'(1) : num_tiles;
      cnt_d   = '0;
      acc_d   = '0;
      sat_d   = '0;
      state_d = S_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tgt_q     <= '0;
      acc_q     <= '0;
      sat_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      dropped_q <= dropped_d;
    end
  end

  assign acc_out   = acc_q;
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign sat       = sat_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a 64-bit instance and a 52-bit instance
// (ACC_WIDTH == PSUM_W) share stimulus so lane saturation can be reached quickly.
module tb_psum_accumulator;

  localparam int N  = 8;
  localparam int PW = 52;
  localparam int AW = 64;
  localparam int NW = 52;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [7:0]      num_tiles;
  logic            psum_valid;
  logic [N*PW-1:0] psums;
  logic            out_ready;

  logic [N*AW-1:0] acc_out;
  logic            out_valid;
  logic            busy;
  logic [N-1:0]    sat;
  logic            dropped;

  logic [N*NW-1:0] acc_out_n;
  logic            out_valid_n;
  logic            busy_n;
  logic [N-1:0]    sat_n;
  logic            dropped_n;

  int checks = 0;
  int errors = 0;

  psum_accumulator #(.ARRAY_SIZE(N), .COL_WIDTH(13), .ACC_WIDTH(AW), .TILE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
    .psum_valid(psum_valid), .psums(psums), .acc_out(acc_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .sat(sat), .dropped(dropped)
  );

  psum_accumulator #(.ARRAY_SIZE(N), .COL_WIDTH(13), .ACC_WIDTH(NW), .TILE_W(8)) dutNarrow (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
    .psum_valid(psum_valid), .psums(psums), .acc_out(acc_out_n), .out_valid(out_valid_n),
    .out_ready(out_ready), .busy(busy_n), .sat(sat_n), .dropped(dropped_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] laneW(input int i);
    return acc_out[i*AW +: AW];
  endfunction

  function automatic logic [63:0] laneN(input int i);
    return {12'h000, acc_out_n[i*NW +: NW]};
  endfunction

  // Drives one cycle: every lane gets base, lane 'lane' gets special.
  task automatic applyStimulus(input logic v, input logic [51:0] base, input int lane,
                               input logic [51:0] special);
    for (int i = 0; i < N; i++) psums[i*PW +: PW] = (i == lane) ? special : base;
    psum_valid = v;
    tick();
    psum_valid = 1'b0;
  endtask

  task automatic startJob(input logic [7:0] tiles);
    start     = 1'b1;
    num_tiles = tiles;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_tiles = '0; psum_valid = 1'b0;
    psums = '0; out_ready = 1'b1;
    tick(); tick();
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_busy",      {63'd0, busy}, 64'd0);
    checkOutput("rst_acc0",      laneW(0), 64'd0);
    checkOutput("rst_sat",       {56'd0, sat}, 64'd0);
    checkOutput("rst_dropped",   {63'd0, dropped}, 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] test1: three tiles");
    startJob(8'd3);
    checkOutput("t1_busy", {63'd0, busy}, 64'd1);
    applyStimulus(1'b1, 52'd1, 0, 52'd5);
    checkOutput("t1_valid_early", {63'd0, out_valid}, 64'd0);
    applyStimulus(1'b1, 52'd1, 0, -52'sd2);
    checkOutput("t1_valid_early2", {63'd0, out_valid}, 64'd0);
    applyStimulus(1'b1, 52'd1, 0, 52'd7);
    checkOutput("t1_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("t1_acc0", laneW(0), 64'd10);
    checkOutput("t1_acc1", laneW(1), 64'd3);
    checkOutput("t1_acc7", laneW(7), 64'd3);
    tick();
    checkOutput("t1_valid_fall", {63'd0, out_valid}, 64'd0);
    checkOutput("t1_idle", {63'd0, busy}, 64'd0);

    $display("[TB] test2: num_tiles zero");
    startJob(8'd0);
    applyStimulus(1'b1, -52'sd1, 0, -52'sd1);
    checkOutput("t2_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("t2_acc0", laneW(0), 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("t2_acc5", laneW(5), 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("t2_sat", {56'd0, sat}, 64'd0);
    checkOutput("t2_accN", laneN(2), 64'h000F_FFFF_FFFF_FFFF);
    tick();

    $display("[TB] test3: lane saturation");
    startJob(8'd2);
    applyStimulus(1'b1, 52'd0, 3, 52'h7_FFFF_FFFF_FFFF);
    applyStimulus(1'b1, 52'd0, 3, 52'd1);
    checkOutput("t3_validN", {63'd0, out_valid_n}, 64'd1);
    checkOutput("t3_accN3", laneN(3), 64'h0007_FFFF_FFFF_FFFF);
    checkOutput("t3_satN", {56'd0, sat_n}, 64'h08);
    checkOutput("t3_accN2", laneN(2), 64'd0);
    checkOutput("t3_accW3", laneW(3), 64'h0008_0000_0000_0000);
    checkOutput("t3_satW", {56'd0, sat}, 64'd0);
    tick();
    startJob(8'd1);
    checkOutput("t3_satN_cleared", {56'd0, sat_n}, 64'd0);
    applyStimulus(1'b1, 52'd4, 0, 52'd4);
    checkOutput("t3_next_accN3", laneN(3), 64'd4);
    checkOutput("t3_dropped_none", {63'd0, dropped}, 64'd0);
    tick();

    $display("[TB] test4: hold under backpressure");
    out_ready = 1'b0;
    startJob(8'd1);
    applyStimulus(1'b1, 52'd6, 0, 52'd6);
    checkOutput("t4_valid", {63'd0, out_valid}, 64'd1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 52'd100, 0, 52'd100);
      checkOutput("t4_hold_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("t4_hold_acc0", laneW(0), 64'd6);
    end
    checkOutput("t4_dropped", {63'd0, dropped}, 64'd1);
    out_ready = 1'b1;
    tick();
    checkOutput("t4_release_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("t4_release_busy", {63'd0, busy}, 64'd0);
    checkOutput("t4_dropped_sticky", {63'd0, dropped}, 64'd1);

    $display("[TB] test5: back-to-back job");
    startJob(8'd1);
    applyStimulus(1'b1, 52'd50, 0, 52'd50);
    checkOutput("t5_first_acc", laneW(0), 64'd50);
    startJob(8'd2);
    checkOutput("t5_busy", {63'd0, busy}, 64'd1);
    checkOutput("t5_valid_fall", {63'd0, out_valid}, 64'd0);
    checkOutput("t5_acc_cleared", laneW(0), 64'd0);
    applyStimulus(1'b1, 52'd3, 0, 52'd3);
    applyStimulus(1'b1, 52'd4, 0, 52'd4);
    checkOutput("t5_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("t5_acc0", laneW(0), 64'd7);
    checkOutput("t5_acc6", laneW(6), 64'd7);
    tick();

    $display("[TB] test6: reset mid-job");
    startJob(8'd4);
    applyStimulus(1'b1, 52'd11, 0, 52'd11);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("t6_busy", {63'd0, busy}, 64'd0);
    checkOutput("t6_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("t6_acc0", laneW(0), 64'd0);
    checkOutput("t6_sat", {56'd0, sat}, 64'd0);
    checkOutput("t6_dropped", {63'd0, dropped}, 64'd0);
    startJob(8'd1);
    applyStimulus(1'b1, 52'd9, 0, 52'd9);
    checkOutput("t6_new_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("t6_new_acc0", laneW(0), 64'd9);
    checkOutput("t6_new_acc7", laneW(7), 64'd9);
    checkOutput("t6_new_accN4", laneN(4), 64'd9);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
